mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Data-side responder to the control path's mem_read/mem_write strobes.
- Accepts one load/store request per access and runs a req/ack transaction on the data bus.
- Steers byte lanes, sign/zero-extends loads, and stalls the pipeline until the access completes.
- Reports misaligned, illegal, bus-error and timeout faults; sits between the control unit/datapath and data memory.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (fixed at 32; lane logic assumes 4 bytes)
- TIMEOUT_CYCLES, 16, max cycles in ACCESS without ack/err before timeout fault (≥1)

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- mem_read  in  1  load request from control path
- mem_write  in  1  store request from control path
- size  in  2  00 byte, 01 half, 10 word, 11 illegal
- unsigned_ld  in  1  1 = zero-extend load, 0 = sign-extend
- addr  in  ADDR_W  byte address
- wdata  in  DATA_W  store data, right-aligned
- rdata  out  DATA_W  extended load data, valid only with done
- done  out  1  one-cycle completion pulse
- stall  out  1  hold pipeline
- fault  out  2  00 none, 01 illegal/misaligned, 10 bus error, 11 timeout; valid with done
- bus_req  out  1  registered bus request
- bus_we  out  1  write strobe
- bus_addr  out  ADDR_W  word-aligned address (low 2 bits 0)
- bus_be  out  4  byte enables
- bus_wdata  out  DATA_W  lane-replicated store data
- bus_ack  in  1  transfer complete
- bus_err  in  1  transfer error
- bus_rdata  in  DATA_W  read data, valid with bus_ack

Behaviour:
- Reset (async, reset_n=0):
  - State goes to IDLE immediately.
  - All outputs go to 0, including bus_req, rdata, done, fault and the timeout counter.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - A request is mem_read|mem_write.
  - On a request, latch addr, wdata, size, unsigned_ld and direction.
  - Legal request: go to ACCESS.
  - Illegal request: go to DONE with fault=01 and no bus activity. Illegal means any of: size=11; half with addr[0]=1; word with addr[1:0]≠0; mem_read and mem_write both high.
- ACCESS:
  - bus_req=1; bus_we, bus_addr, bus_be and bus_wdata come from the latched values and stay stable while bus_req=1.
  - bus_err sampled high: go to DONE, fault=10. bus_err wins over a simultaneous bus_ack.
  - bus_ack sampled high: latch the extended bus_rdata (reads) and go to DONE, fault=00.
  - Counter reaches TIMEOUT_CYCLES with neither: go to DONE, fault=11.
  - bus_req deasserts on entry to DONE in all cases.
- DONE:
  - done=1 for exactly one cycle; fault and rdata are held valid there.
  - Next state is always IDLE.
  - Requests present in DONE are ignored. A request still asserted in the following IDLE cycle is a new access.
- stall (combinational) = (IDLE & request) | ACCESS. stall=0 in DONE.
- Latency: request cycle N; with bus_ack in the first ACCESS cycle (N+1), done is at N+2. An illegal request gives done at N+1.
- Lanes (little-endian):
  - byte: be = 0001<<addr[1:0], wdata[7:0] replicated ×4.
  - half: be = 0011<<addr[1:0], wdata[15:0] replicated ×2.
  - word: be = 1111.
  - Stores with fault=00 are committed; rdata=0 for stores.
- Load extension: select lane by latched addr[1:0]; sign- or zero-extend per unsigned_ld. On a fault, rdata=0.
- Unexpected bus_ack/bus_err outside ACCESS are ignored.
- Reset mid-ACCESS: bus_req drops asynchronously and the access is abandoned with no done pulse.

Decomposition:
- Shared package mcu32x_mem_pkg holds:
  - size encodings (SZ_BYTE, SZ_HALF, SZ_WORD)
  - fault codes (FLT_NONE, FLT_ILLEGAL, FLT_BUSERR, FLT_TIMEOUT)
  - FSM state encoding
- One combinational sub-module, load_store_align: computes bus_be, replicated wdata, the misalignment flag, and the extended load data from size, addr[1:0] and unsigned_ld.

Test Plan:
- Store word, addr=0x100, wdata=0xDEADBEEF, ack on first ACCESS cycle -> bus_addr=0x100, bus_be=1111, bus_we=1, done at N+2, fault=00, stall high N..N+1.
- Signed byte load, addr=0x103, bus_rdata=0x80123456 -> rdata=0xFFFFFF80; repeat with unsigned_ld=1 -> 0x00000080.
- Half store at addr=0x101 -> bus_req never asserts, done at N+1, fault=01; same result for mem_read=mem_write=1 at addr=0x100.
- Load with no ack, TIMEOUT_CYCLES=16 -> bus_req high exactly 16 cycles, then done with fault=11, rdata=0.
- bus_ack and bus_err in the same cycle -> fault=10, rdata=0; store half at 0x102 -> bus_be=1100, bus_wdata=0xBEEFBEEF for wdata=0x0000BEEF.
- reset_n low mid-ACCESS -> bus_req=0 immediately, no done pulse; after release a word load at 0x10 completes normally.

Source files
------------

// File: rtl/mcu32x_mem_pkg.sv
// Shared encodings for the data-side memory access unit.
package mcu32x_mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'b00,
    SZ_HALF    = 2'b01,
    SZ_WORD    = 2'b10,
    SZ_ILLEGAL = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    FLT_NONE    = 2'b00,
    FLT_ILLEGAL = 2'b01,
    FLT_BUSERR  = 2'b10,
    FLT_TIMEOUT = 2'b11
  } fault_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } state_e;

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering for a 32-bit little-endian data bus: byte enables,
// replicated store data, alignment check and extended load data.
module load_store_align
  import mcu32x_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        unsigned_ld,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic        misaligned,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte/half lane, then steer and extend by access size.
  always_comb begin
    be         = 4'b0000;
    wdata_rep  = wdata;
    misaligned = 1'b0;
    ld_data    = bus_rdata;
    case (addr_lo)
      2'd0:    byte_sel = bus_rdata[7:0];
      2'd1:    byte_sel = bus_rdata[15:8];
      2'd2:    byte_sel = bus_rdata[23:16];
      default: byte_sel = bus_rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (size_e'(size))
      SZ_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        ld_data   = {{24{byte_sel[7] & ~unsigned_ld}}, byte_sel};
      end
      SZ_HALF: begin
        be         = 4'b0011 << addr_lo;
        wdata_rep  = {2{wdata[15:0]}};
        ld_data    = {{16{half_sel[15] & ~unsigned_ld}}, half_sel};
        misaligned = addr_lo[0];
      end
      SZ_WORD: begin
        be         = 4'b1111;
        misaligned = |addr_lo;
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store responder: turns mem_read/mem_write strobes into one req/ack
// bus transaction, stalls the pipeline meanwhile and reports faults.
module mem_access_unit
  import mcu32x_mem_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              stall,
  output logic [1:0]        fault,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic              bus_err,
  input  logic [DATA_W-1:0] bus_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e            state, state_next;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [1:0]        lat_size;
  logic              lat_uns;
  logic              lat_we;
  logic [CNT_W-1:0]  tcount;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        fault_q;

  logic              in_idle;
  logic              request;
  logic              illegal;
  logic              timeout;
  logic [1:0]        al_size;
  logic [1:0]        al_addr_lo;
  logic [3:0]        al_be;
  logic [DATA_W-1:0] al_wdata_rep;
  logic [DATA_W-1:0] al_ld;
  logic              al_mis;

  assign in_idle = (state == ST_IDLE);
  assign request = mem_read | mem_write;

  // In IDLE the aligner judges the live request; afterwards it works from
  // the latched copy so the bus fields stay stable for the whole access.
  assign al_size    = in_idle ? size : lat_size;
  assign al_addr_lo = in_idle ? addr[1:0] : lat_addr[1:0];

  load_store_align u_align (
    .size       (al_size),
    .addr_lo    (al_addr_lo),
    .unsigned_ld(lat_uns),
    .wdata      (lat_wdata),
    .bus_rdata  (bus_rdata),
    .be         (al_be),
    .wdata_rep  (al_wdata_rep),
    .misaligned (al_mis),
    .ld_data    (al_ld)
  );

  assign illegal = al_mis | (mem_read & mem_write);
  assign timeout = (tcount == CNT_W'(TIMEOUT_CYCLES - 1));

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Next-state logic: bus_err, bus_ack and timeout all end an access.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (request) state_next = illegal ? ST_DONE : ST_ACCESS;
      ST_ACCESS: if (bus_err || bus_ack || timeout) state_next = ST_DONE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Request latching, timeout counting and result capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_size  <= '0;
      lat_uns   <= 1'b0;
      lat_we    <= 1'b0;
      tcount    <= '0;
      rdata_q   <= '0;
      fault_q   <= FLT_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          tcount <= '0;
          if (request) begin
            lat_addr  <= addr;
            lat_wdata <= wdata;
            lat_size  <= size;
            lat_uns   <= unsigned_ld;
            lat_we    <= mem_write;
            if (illegal) begin
              fault_q <= FLT_ILLEGAL;
              rdata_q <= '0;
            end
          end
        end
        ST_ACCESS: begin
          tcount <= tcount + CNT_W'(1);
          if (bus_err) begin
            fault_q <= FLT_BUSERR;
            rdata_q <= '0;
          end else if (bus_ack) begin
            fault_q <= FLT_NONE;
            rdata_q <= lat_we ? '0 : al_ld;
          end else if (timeout) begin
            fault_q <= FLT_TIMEOUT;
            rdata_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // bus_req is decoded straight from the state flop, so it is glitch-free
  // and drops the instant reset asserts.
  assign bus_req   = (state == ST_ACCESS);
  assign bus_we    = bus_req & lat_we;
  assign bus_addr  = bus_req ? {lat_addr[ADDR_W-1:2], 2'b00} : '0;
  assign bus_be    = bus_req ? al_be : 4'b0000;
  assign bus_wdata = bus_req ? al_wdata_rep : '0;

  assign done  = (state == ST_DONE);
  assign fault = done ? fault_q : FLT_NONE;
  assign rdata = done ? rdata_q : '0;
  assign stall = (in_idle & request) | bus_req;

endmodule
